// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port byte-enable block RAM.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers cast to their own width.
  localparam int MAX_DATA = 1024;
  localparam int MAX_NB   = 1024;

  function automatic int nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Bit i takes new_w when the lane it belongs to is enabled, else keeps old_w.
  function automatic logic [MAX_DATA-1:0] lane_merge(input logic [MAX_DATA-1:0] old_w,
                                                     input logic [MAX_DATA-1:0] new_w,
                                                     input logic [MAX_NB-1:0]   we,
                                                     input int                  byte_w);
    logic [MAX_DATA-1:0] merged;
    merged = old_w;
    for (int i = 0; i < MAX_DATA; i++)
      if (we[i / byte_w]) merged[i] = new_w[i];
    return merged;
  endfunction

endpackage

// File: rtl/bram_2psync_be_if.sv
// One RAM port: access request from the master, read data and valid back from the RAM.
interface bram_2psync_be_if
  import bram_pkg::*;
#(
  parameter int DATA = 32,
  parameter int ADDR = 10,
  parameter int BYTE = 8
);
  localparam int NB = nb(DATA, BYTE);

  logic            en;
  logic [NB-1:0]   we;
  logic [ADDR-1:0] addr;
  logic [DATA-1:0] write;
  logic [DATA-1:0] read;
  logic            rvalid;

  modport master (output en, we, addr, write, input read, rvalid);
  modport slave  (input en, we, addr, write, output read, rvalid);
endinterface

// File: rtl/bram_rd_pipe.sv
// Per-port read data / rvalid register stage; BRAM_2PSYNC_OUTREG_EN adds a second stage.
module bram_rd_pipe #(
  parameter int DATA = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout,
  output logic            rvalid
);
  logic [DATA-1:0] rd_p0;
  logic            vld_p0;

  // Stage 0: array output capture, held while the port is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= en;
      if (en) rd_p0 <= din;
    end
  end

`ifdef BRAM_2PSYNC_OUTREG_EN
  logic [DATA-1:0] rd_p1;
  logic            vld_p1;

  // Stage 1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) rd_p1 <= rd_p0;
    end
  end

  assign dout   = rd_p1;
  assign rvalid = vld_p1;
`else
  assign dout   = rd_p0;
  assign rvalid = vld_p0;
`endif

endmodule

// File: rtl/bram_2psync_be.sv
// True dual-port synchronous RAM with byte enables and cross-port collision counting.
// Optional macro BRAM_2PSYNC_OUTREG_EN adds an output register (read latency 2).
module bram_2psync_be
  import bram_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int ADDR     = 10,
  parameter int BYTE     = 8,
  parameter int RDW_MODE = RDW_WRITE_FIRST,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_2psync_be_if.slave     a,
  bram_2psync_be_if.slave     b,
  output logic                coll,
  output logic [CNT_W-1:0]    coll_cnt,
  input  logic                coll_clr
);
  localparam int NB = nb(DATA, BYTE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [DATA-1:0] merge_w(input logic [DATA-1:0] old_w,
                                              input logic [DATA-1:0] new_w,
                                              input logic [NB-1:0]   we);
    return DATA'(lane_merge(MAX_DATA'(old_w), MAX_DATA'(new_w), MAX_NB'(we), BYTE));
  endfunction

  logic [DATA-1:0] mem [2**ADDR];
  logic [DATA-1:0] a_old, b_old, a_rd, b_rd, a_wr_word, b_wr_word;
  logic            a_wr, b_wr, coll_hit;

  assign a_old = mem[a.addr];
  assign b_old = mem[b.addr];
  assign a_wr  = a.en & (|a.we);
  assign b_wr  = b.en & (|b.we);

  // On a same-address double write, A merges on top of B's word so A wins shared lanes.
  assign b_wr_word = merge_w(b_old, b.write, b.we);
  assign a_wr_word = merge_w((b_wr && (b.addr == a.addr)) ? b_wr_word : a_old, a.write, a.we);

  // Own-port writes may forward; the other port's write is never visible this cycle.
  assign a_rd = (RDW_MODE == RDW_WRITE_FIRST) ? merge_w(a_old, a.write, a.we) : a_old;
  assign b_rd = (RDW_MODE == RDW_WRITE_FIRST) ? merge_w(b_old, b.write, b.we) : b_old;

  always_ff @(posedge clk) begin
    if (b_wr) mem[b.addr] <= b_wr_word;
    if (a_wr) mem[a.addr] <= a_wr_word;
  end

  assign coll_hit = a.en & b.en & (a.addr == b.addr) & ((|a.we) | (|b.we));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= coll_hit;
      if (coll_clr)
        coll_cnt <= coll_hit ? CNT_W'(1) : '0;
      else if (coll_hit && (coll_cnt != CNT_MAX))
        coll_cnt <= coll_cnt + 1'b1;
    end
  end

  bram_rd_pipe #(.DATA(DATA)) u_rd_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (a.en),
    .din    (a_rd),
    .dout   (a.read),
    .rvalid (a.rvalid)
  );

  bram_rd_pipe #(.DATA(DATA)) u_rd_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (b.en),
    .din    (b_rd),
    .dout   (b.read),
    .rvalid (b.rvalid)
  );

endmodule

// File: tb/tb_bram_2psync_be.sv
// Directed bench: a WRITE_FIRST and a READ_FIRST instance driven identically, CNT_W=2.
module tb_bram_2psync_be;
  import bram_pkg::*;

`ifdef BRAM_2PSYNC_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coll_clr = 1'b0;
  logic       coll_w, coll_r;
  logic [1:0] cnt_w, cnt_r;
  logic       coll_seen;
  logic [1:0] cnt_seen;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bram_2psync_be_if #(.DATA(32), .ADDR(10), .BYTE(8)) ifa_w ();
  bram_2psync_be_if #(.DATA(32), .ADDR(10), .BYTE(8)) ifb_w ();
  bram_2psync_be_if #(.DATA(32), .ADDR(10), .BYTE(8)) ifa_r ();
  bram_2psync_be_if #(.DATA(32), .ADDR(10), .BYTE(8)) ifb_r ();

  bram_2psync_be #(.DATA(32), .ADDR(10), .BYTE(8), .RDW_MODE(RDW_WRITE_FIRST), .CNT_W(2)) dut_wf (
    .clk(clk), .rst_n(rst_n), .a(ifa_w), .b(ifb_w),
    .coll(coll_w), .coll_cnt(cnt_w), .coll_clr(coll_clr));

  bram_2psync_be #(.DATA(32), .ADDR(10), .BYTE(8), .RDW_MODE(RDW_READ_FIRST), .CNT_W(2)) dut_rf (
    .clk(clk), .rst_n(rst_n), .a(ifa_r), .b(ifb_r),
    .coll(coll_r), .coll_cnt(cnt_r), .coll_clr(coll_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [3:0] awe, input logic [9:0] aad,
                       input logic [31:0] awd, input logic be, input logic [3:0] bwe,
                       input logic [9:0] bad, input logic [31:0] bwd);
    ifa_w.en = ae; ifa_w.we = awe; ifa_w.addr = aad; ifa_w.write = awd;
    ifa_r.en = ae; ifa_r.we = awe; ifa_r.addr = aad; ifa_r.write = awd;
    ifb_w.en = be; ifb_w.we = bwe; ifb_w.addr = bad; ifb_w.write = bwd;
    ifb_r.en = be; ifb_r.we = bwe; ifb_r.addr = bad; ifb_r.write = bwd;
  endtask

  task automatic idle;
    drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  // One access cycle; coll/coll_cnt captured the cycle after issue, reads at LAT.
  task automatic access(input logic ae, input logic [3:0] awe, input logic [9:0] aad,
                        input logic [31:0] awd, input logic be, input logic [3:0] bwe,
                        input logic [9:0] bad, input logic [31:0] bwd);
    drive(ae, awe, aad, awd, be, bwe, bad, bwd);
    cyc;
    coll_seen = coll_w;
    cnt_seen  = cnt_w;
    idle;
    repeat (LAT - 1) cyc;
  endtask

  task automatic wr_a(input logic [3:0] we, input logic [9:0] ad, input logic [31:0] d);
    access(1'b1, we, ad, d, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic rd_a(input logic [9:0] ad);
    access(1'b1, 4'h0, ad, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  initial begin
    idle;
    repeat (2) cyc;
    chk("reset a_read", ifa_w.read, 32'h0);
    chk("reset a_rvalid", 32'(ifa_w.rvalid), 32'h0);
    chk("reset b_rvalid", 32'(ifb_w.rvalid), 32'h0);
    chk("reset coll", 32'(coll_w), 32'h0);
    chk("reset coll_cnt", 32'(cnt_w), 32'h0);
    rst_n = 1'b1;
    cyc;

    wr_a(4'hF, 10'h010, 32'hDEADBEEF);
    chk("write return wf", ifa_w.read, 32'hDEADBEEF);
    chk("write rvalid", 32'(ifa_w.rvalid), 32'h1);
    rd_a(10'h010);
    chk("read 0x010", ifa_w.read, 32'hDEADBEEF);
    chk("read rvalid", 32'(ifa_w.rvalid), 32'h1);
    chk("no coll cnt", 32'(cnt_w), 32'h0);
    cyc;
    chk("idle rvalid", 32'(ifa_w.rvalid), 32'h0);
    chk("idle hold", ifa_w.read, 32'hDEADBEEF);

    wr_a(4'hF, 10'h005, 32'h11223344);
    wr_a(4'b0101, 10'h005, 32'hAABBCCDD);
    chk("partial wf return", ifa_w.read, 32'h11BB33DD);
    chk("partial rf return", ifa_r.read, 32'h11223344);
    rd_a(10'h005);
    chk("byte lanes", ifa_w.read, 32'h11BB33DD);

    wr_a(4'hF, 10'h007, 32'h0);
    access(1'b1, 4'hF, 10'h007, 32'h55, 1'b1, 4'h0, 10'h007, 32'h0);
    chk("rdw write_first", ifa_w.read, 32'h55);
    chk("rdw read_first", ifa_r.read, 32'h0);
    chk("cross read wf", ifb_w.read, 32'h0);
    chk("cross read rf", ifb_r.read, 32'h0);
    chk("rdw coll", 32'(coll_seen), 32'h1);
    chk("rdw coll_cnt", 32'(cnt_seen), 32'h1);
    rd_a(10'h007);
    chk("addr7 after", ifa_w.read, 32'h55);

    wr_a(4'hF, 10'h003, 32'h0);
    access(1'b1, 4'b0011, 10'h003, 32'hAAAAAAAA, 1'b1, 4'b0110, 10'h003, 32'hBBBBBBBB);
    chk("ww coll", 32'(coll_seen), 32'h1);
    chk("ww coll_cnt", 32'(cnt_seen), 32'h2);
    chk("ww a return", ifa_w.read, 32'h0000AAAA);
    chk("ww b return wf", ifb_w.read, 32'h00BBBB00);
    chk("ww b return rf", ifb_r.read, 32'h0);
    rd_a(10'h003);
    chk("ww memory", ifa_w.read, 32'h00BBAAAA);

    coll_clr = 1'b1;
    cyc;
    coll_clr = 1'b0;
    chk("clr alone", 32'(cnt_w), 32'h0);
    for (int i = 0; i < 5; i++)
      access(1'b1, 4'h0, 10'h020, 32'h0, 1'b1, 4'hF, 10'h020, 32'h1);
    chk("sat coll", 32'(coll_seen), 32'h1);
    chk("sat coll_cnt", 32'(cnt_seen), 32'h3);
    coll_clr = 1'b1;
    drive(1'b1, 4'h0, 10'h020, 32'h0, 1'b1, 4'hF, 10'h020, 32'h1);
    cyc;
    coll_clr = 1'b0;
    idle;
    chk("clr with coll", 32'(cnt_w), 32'h1);
    repeat (LAT) cyc;
    access(1'b1, 4'h0, 10'h020, 32'h0, 1'b1, 4'h0, 10'h020, 32'h0);
    chk("rr no coll", 32'(coll_seen), 32'h0);
    chk("rr cnt held", 32'(cnt_seen), 32'h1);
    chk("rr a data", ifa_w.read, 32'h1);
    chk("rr b data", ifb_r.read, 32'h1);

    // Reset lands between the read issue and the edge that would return it.
    drive(1'b1, 4'h0, 10'h010, 32'h0, 1'b0, 4'h0, 10'h0, 32'h0);
    #2 rst_n = 1'b0;
    cyc;
    chk("rst mid rvalid", 32'(ifa_w.rvalid), 32'h0);
    idle;
    cyc;
    rst_n = 1'b1;
    cyc;
    chk("post rst rvalid", 32'(ifa_w.rvalid), 32'h0);
    chk("post rst a_read", ifa_w.read, 32'h0);
    chk("post rst cnt", 32'(cnt_w), 32'h0);
    rd_a(10'h010);
    chk("survive 0x010", ifa_w.read, 32'hDEADBEEF);
    rd_a(10'h005);
    chk("survive 0x005", ifa_r.read, 32'h11BB33DD);
    rd_a(10'h007);
    chk("survive 0x007", ifa_r.read, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_2psync_be.md
Name: bram_2psync_be

Overview:
- Parametrised true dual-port synchronous block RAM; successor to the fixed 8-bit, single-write-port 2psync RAMs.
- Both ports can read and write, with per-byte write enables and a selectable read-during-write mode.
- Read-valid handshake per port, plus cross-port collision detection with a saturating counter.
- Used as CPU/DMA shared memory and as a writable boot ROM on ECP5 targets; infers EBR.

Parameters:
- DATA, 32, word width in bits; must be a multiple of BYTE.
- ADDR, 10, address width; depth is 2**ADDR words.
- BYTE, 8, byte-lane width; NB = DATA/BYTE lanes.
- RDW_MODE, 1, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- CNT_W, 8, collision counter width.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A access enable.
- a_we  in  NB  port A byte write enables; qualified by a_en.
- a_addr  in  ADDR  port A word address.
- a_write  in  DATA  port A write data.
- a_read  out  DATA  port A read data.
- a_rvalid  out  1  a_read holds the result of an access.
- b_en, b_we, b_addr, b_write, b_read, b_rvalid: identical to port A.
- coll  out  1  one-cycle pulse, registered, when a collision occurred.
- coll_cnt  out  CNT_W  saturating collision count.
- coll_clr  in  1  synchronous clear of coll_cnt.

Behaviour:
- Reset (async assert, sync release):
  - a_read, b_read, a_rvalid, b_rvalid, coll and coll_cnt go to 0.
  - Memory array is not reset; contents survive reset.
  - An in-flight read is dropped; rvalid does not assert for any access issued before reset.
- Access: x_en=1 in cycle N is one access.
  - Lane i is written when x_we[i]=1.
  - Every enabled access, write or read, returns data: x_read is valid and x_rvalid=1 in cycle N+1 (latency 1).
  - x_rvalid=0 in any cycle after one with x_en=0.
  - x_read holds its last value while x_en=0.
- Same-port read-during-write, per lane:
  - RDW_MODE=1: written lanes return new data; unwritten lanes return stored data.
  - RDW_MODE=0: all lanes return pre-write data.
- Cross-port read vs write, same address, same cycle: the reader always gets old data (read-first), whatever RDW_MODE is.
- Write-write, same address, same cycle:
  - Port A wins on lanes where both we bits are set.
  - Lanes written by only one port take that port's data.
- Collision: a_en & b_en & (a_addr==b_addr) & (|a_we | |b_we) in cycle N. Then coll=1 in N+1 and coll_cnt increments.
  - Read-read to the same address is not a collision.
- coll_cnt:
  - Saturates at 2**CNT_W-1; no wrap.
  - coll_clr alone clears it to 0.
  - coll_clr together with a collision loads 1.
- Address wrap: none; the full 2**ADDR range is addressable.
- x_we nonzero with x_en=0: ignored, no write.

Optional Feature:
- Macro: BRAM_2PSYNC_OUTREG_EN.
- Defined: an extra output register on a_read/b_read and the rvalid pipeline, giving read latency 2.
  - rvalid asserts in cycle N+2.
  - The pipeline register resets to 0.
  - Back-to-back accesses stream one per cycle.
- Undefined: latency 1 as above; no extra flops.
- coll timing is unchanged in both cases.

Decomposition:
- Package bram_pkg holds:
  - constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - a function for the lane count, nb(DATA, BYTE);
  - the lane-merge helper.
- Sub-module bram_rd_pipe, instantiated per port, holds the rvalid/read-data register stage(s) and the optional OUTREG stage.
- The memory array and collision logic stay in the top level.

Test Plan:
- Reset, then A writes 0xDEADBEEF at addr 0x010 with a_we=4'hF; A reads 0x010 next cycle -> a_read=0xDEADBEEF and a_rvalid=1 one cycle after the read (two with OUTREG); coll_cnt=0.
- Byte lanes: A writes 0x11223344 at addr 5, then A writes 0xAABBCCDD with a_we=4'b0101 -> read returns 0x11BB33DD.
- RDW, with addr 7 holding 0x0 and A writing 0x55 at addr 7 with we=F:
  - RDW_MODE=1 -> same-cycle a_read=0x55.
  - RDW_MODE=0 -> a_read=0x0.
  - B reading addr 7 in the same cycle -> b_read=0x0; coll=1; coll_cnt=1.
- Write-write at addr 3: A writes 0xAAAAAAAA with we=4'b0011; B writes 0xBBBBBBBB with we=4'b0110 -> memory holds 0x00BBAAAA (assuming prior 0); coll pulse.
- Saturation with CNT_W=2: 5 collisions -> coll_cnt=3. Then coll_clr together with a collision -> coll_cnt=1. Then a read-read to the same address -> coll stays 0.
- Assert rst_n low for 1 cycle mid-stream, between a read issue and its result -> a_rvalid=0 after reset; earlier written data is still readable afterwards.
